// File: rtl/lcm_req_chk.sv
// Request front end and result checker for one lcm core instance.
// Issues operand pairs to the core, then checks lcm*gcd == A*B and the range rules on the result.
module lcm_req_chk #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TMO_CYC = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_W-1:0]     req_a,
  input  logic [DATA_W-1:0]     req_b,
  output logic [DATA_W-1:0]     A,
  output logic [DATA_W-1:0]     B,
  output logic                  vld_in,
  input  logic [2*DATA_W-1:0]   lcm_out,
  input  logic [DATA_W-1:0]     mcd_out,
  input  logic                  vld_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*DATA_W-1:0]   rsp_lcm,
  output logic [DATA_W-1:0]     rsp_mcd,
  output logic [1:0]            rsp_err,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int unsigned TMR_W = $clog2(TMO_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CHECK,
    S_DRAIN,
    S_ZERO,
    S_RESP
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                vld_in_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [2*DATA_W-1:0] lcm_q;
  logic [DATA_W-1:0]   mcd_q;
  logic [1:0]          err_q;
  logic [CNT_W-1:0]    err_cnt_q;
  logic [TMR_W-1:0]    tmr_q;

  logic [3*DATA_W-1:0] prod_lm, prod_ab;
  logic [2*DATA_W-1:0] ab;
  logic [DATA_W-1:0]   op_min, op_max;
  logic                chk_err_d;

  // Both products are formed at full width so an overflowing core result cannot alias.
  always_comb begin
    ab        = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
    prod_ab   = {{DATA_W{1'b0}}, ab};
    prod_lm   = {{DATA_W{1'b0}}, lcm_q} * {{(2*DATA_W){1'b0}}, mcd_q};
    op_min    = (a_q < b_q) ? a_q : b_q;
    op_max    = (a_q < b_q) ? b_q : a_q;
    chk_err_d = (mcd_q == '0) || (mcd_q > op_min) ||
                (lcm_q < {{DATA_W{1'b0}}, op_max}) || (prod_lm != prod_ab);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      vld_in_q    <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      lcm_q       <= '0;
      mcd_q       <= '0;
      err_q       <= '0;
      err_cnt_q   <= '0;
      tmr_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            a_q         <= req_a;
            b_q         <= req_b;
            req_ready_q <= 1'b0;
            tmr_q       <= TMR_W'(1);
            if (req_a == '0 || req_b == '0) begin
              state_q <= S_ZERO;
            end else begin
              state_q  <= S_ISSUE;
              vld_in_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // A result arriving on the final timer cycle takes priority over the timeout.
          if (vld_out) begin
            lcm_q    <= lcm_out;
            mcd_q    <= mcd_out;
            vld_in_q <= 1'b0;
            state_q  <= S_CHECK;
          end else if (tmr_q == TMR_W'(TMO_CYC)) begin
            vld_in_q <= 1'b0;
            state_q  <= S_DRAIN;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        S_CHECK: begin
          err_q       <= {1'b0, chk_err_d};
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_DRAIN: begin
          lcm_q       <= '0;
          mcd_q       <= '0;
          err_q       <= 2'b10;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_ZERO: begin
          lcm_q       <= '0;
          mcd_q       <= a_q | b_q;
          err_q       <= '0;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
            if (err_q != '0 && err_cnt_q != '1) begin
              err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign A         = a_q;
  assign B         = b_q;
  assign vld_in    = vld_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_lcm   = lcm_q;
  assign rsp_mcd   = mcd_q;
  assign rsp_err   = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_lcm_req_chk.sv
// Randomized bench for lcm_req_chk: emulates the core and compares responses against an arithmetic model.
module tb_lcm_req_chk;

  localparam int unsigned DW  = 8;
  localparam int unsigned TMO = 16;
  localparam int unsigned CW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_a = '0, req_b = '0;
  logic [DW-1:0] A, B;
  logic          vld_in;
  logic [2*DW-1:0] lcm_out = '0;
  logic [DW-1:0] mcd_out = '0;
  logic          vld_out = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [2*DW-1:0] rsp_lcm;
  logic [DW-1:0] rsp_mcd;
  logic [1:0]    rsp_err;
  logic [CW-1:0] err_cnt;

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned exp_cnt = 0;

  lcm_req_chk #(.DATA_W(DW), .TMO_CYC(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .A(A), .B(B), .vld_in(vld_in),
    .lcm_out(lcm_out), .mcd_out(mcd_out), .vld_out(vld_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lcm(rsp_lcm), .rsp_mcd(rsp_mcd), .rsp_err(rsp_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned gcd(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic void model(input logic [7:0] a, input logic [7:0] b, input bit hang,
                                input logic [15:0] l, input logic [7:0] m,
                                output logic [15:0] el, output logic [7:0] em,
                                output logic [1:0] ee);
    longint unsigned la = a, lb = b, ll = l, lm = m;
    longint unsigned mn = (la < lb) ? la : lb;
    longint unsigned mx = (la < lb) ? lb : la;
    if (a == 0 || b == 0) begin
      el = '0; em = a | b; ee = 2'b00;
    end else if (hang) begin
      el = '0; em = '0; ee = 2'b10;
    end else begin
      el = l; em = m;
      ee = {1'b0, (lm == 0) || (lm > mn) || (ll < mx) || (ll * lm != la * lb)};
    end
  endfunction

  task automatic txn(input logic [7:0] a, input logic [7:0] b, input int lat,
                     input logic [15:0] l, input logic [7:0] m, input bit hang,
                     input int hold, input bit stray);
    logic [15:0] el;
    logic [7:0]  em;
    logic [1:0]  ee;
    int cyc;
    model(a, b, hang, l, m, el, em, ee);
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    check("req_ready_before", req_ready, 1);
    req_valid = 1'b1; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0; req_a = DW'($urandom); req_b = DW'($urandom);
    if (a == 0 || b == 0) begin
      check("zero_vld_in_c1", vld_in, 0);
      check("zero_rsp_valid_c1", rsp_valid, 0);
      @(negedge clk);
      check("zero_vld_in_c2", vld_in, 0);
      check("zero_rsp_valid_c2", rsp_valid, 1);
    end else begin
      check("vld_in_c1", vld_in, 1);
      check("A_c1", A, a);
      check("B_c1", B, b);
      if (hang) begin
        cyc = 0;
        while (vld_in && cyc < 100) begin
          cyc++;
          @(negedge clk);
        end
        check("tmo_issue_cycles", cyc, TMO);
        check("drain_rsp_valid", rsp_valid, 0);
        @(negedge clk);
      end else begin
        for (int i = 1; i < lat; i++) @(negedge clk);
        check("vld_in_held", vld_in, 1);
        check("A_held", A, a);
        check("B_held", B, b);
        vld_out = 1'b1; lcm_out = l; mcd_out = m;
        @(negedge clk);
        vld_out = 1'b0; lcm_out = 16'($urandom); mcd_out = DW'($urandom);
        check("vld_in_dropped", vld_in, 0);
        check("check_rsp_valid", rsp_valid, 0);
        @(negedge clk);
      end
      check("rsp_valid", rsp_valid, 1);
    end
    check("rsp_lcm", rsp_lcm, el);
    check("rsp_mcd", rsp_mcd, em);
    check("rsp_err", rsp_err, ee);
    for (int i = 0; i < hold; i++) begin
      if (stray && i == hold / 2) begin
        vld_out = 1'b1; lcm_out = 16'($urandom); mcd_out = DW'($urandom);
      end
      @(negedge clk);
      vld_out = 1'b0;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_lcm", rsp_lcm, el);
      check("hold_rsp_mcd", rsp_mcd, em);
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (ee != 2'b00 && exp_cnt < 3) exp_cnt++;
    check("rsp_valid_drop", rsp_valid, 0);
    check("req_ready_after", req_ready, 1);
    check("err_cnt", err_cnt, exp_cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] ra, rb, rm;
    logic [15:0] rl;
    int mode;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_req_ready", req_ready, 1);
    check("rst_A", A, 0);
    check("rst_B", B, 0);
    check("rst_vld_in", vld_in, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_lcm", rsp_lcm, 0);
    check("rst_rsp_mcd", rsp_mcd, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_err_cnt", err_cnt, 0);

    txn(8'd6, 8'd7, 5, 16'd42, 8'd1, 1'b0, 0, 1'b0);
    txn(8'd12, 8'd8, 3, 16'd24, 8'd4, 1'b0, 1, 1'b0);
    txn(8'd15, 8'd20, 2, 16'd60, 8'd10, 1'b0, 0, 1'b0);
    txn(8'd9, 8'd6, 0, 16'd0, 8'd0, 1'b1, 0, 1'b0);
    txn(8'd10, 8'd4, TMO, 16'd20, 8'd2, 1'b0, 0, 1'b0);
    txn(8'd0, 8'd5, 0, 16'd0, 8'd0, 1'b0, 0, 1'b0);
    txn(8'd0, 8'd0, 0, 16'd0, 8'd0, 1'b0, 0, 1'b0);
    txn(8'd4, 8'd6, 1, 16'd12, 8'd3, 1'b0, 10, 1'b1);
    txn(8'd5, 8'd3, 4, 16'd7, 8'd1, 1'b0, 10, 1'b1);

    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_a = 8'd100; req_b = 8'd30;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstmid_vld_in_before", vld_in, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_vld_in", vld_in, 0);
    check("rstmid_rsp_valid", rsp_valid, 0);
    check("rstmid_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    check("rstmid_req_ready", req_ready, 1);
    txn(8'd255, 8'd254, 3, 16'd64770, 8'd1, 1'b0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      mode = $urandom_range(0, 9);
      if (mode <= 3) begin
        rl = 16'($urandom);
        rm = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      end else if (ra != 0 && rb != 0) begin
        rm = 8'(gcd(ra, rb));
        rl = 16'((int'(ra) * int'(rb)) / int'(rm));
      end else begin
        rl = '0; rm = '0;
      end
      txn(ra, rb, $urandom_range(1, TMO), rl, rm, mode == 0, $urandom_range(0, 3),
          1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
